instruction_fetch_unit: RTL and testbench

- Sits directly downstream of the program counter.
- Takes the current PC value and fetches the 16-bit instruction word from instruction memory over a req/ready handshake.
- Latches the word into the instruction register and pulses completion back to the multi-cycle control unit.
- Detects misaligned PCs (PC advances by 2, byte-addressed, word-aligned) and, optionally, memory timeouts.

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: takes the current PC, reads one instruction word from
// instruction memory over a req/ready handshake, latches it into the IR and
// pulses completion back to the control unit. Misaligned PCs raise a fault.
// Optional feature macro: FETCH_TIMEOUT_EN -- when defined, a wait-state
// counter aborts a fetch that sees no ready within TIMEOUT_CYCLES cycles.
module instruction_fetch_unit #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              input_reset,
  input  logic [ADDR_W-1:0] input_PC,
  input  logic              input_fetch_start,
  input  logic              input_fault_clear,
  input  logic              input_mem_ready,
  input  logic [DATA_W-1:0] input_mem_rdata,
  output logic              output_mem_req,
  output logic [ADDR_W-1:0] output_mem_addr,
  output logic [DATA_W-1:0] output_IR,
  output logic [3:0]        output_opcode,
  output logic              output_fetch_done,
  output logic              output_busy,
  output logic              output_fault,
  output logic [1:0]        output_fault_code
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
  localparam int         CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
  // Limit is checked against the count before the increment, so the fault
  // fires on the TIMEOUT_CYCLES-th ready-less cycle in REQ.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        code_q, code_d;
`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (input_reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      addr_q  <= '0;
      code_q  <= CODE_NONE;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and register-update logic; starts outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    code_d  = code_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (input_fetch_start) begin
          if (input_PC[0]) begin
            state_d = S_FAULT;
            code_d  = CODE_MISALIGN;
          end else begin
            state_d = S_REQ;
            addr_d  = input_PC;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (input_mem_ready) begin
          state_d = S_DONE;
          ir_d    = input_mem_rdata;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          // Ready on the limit edge is handled above, so it wins over timeout.
          if (cnt_q == CNT_LAST) begin
            state_d = S_FAULT;
            code_d  = CODE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (input_fault_clear) begin
          state_d = S_IDLE;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded purely from the current state.
  always_comb begin
    output_mem_req    = 1'b0;
    output_fetch_done = 1'b0;
    output_busy       = 1'b1;
    output_fault      = 1'b0;
    case (state_q)
      S_IDLE:  output_busy       = 1'b0;
      S_REQ:   output_mem_req    = 1'b1;
      S_DONE:  output_fetch_done = 1'b1;
      S_FAULT: output_fault      = 1'b1;
      default: output_busy       = 1'b0;
    endcase
  end

  assign output_mem_addr   = addr_q;
  assign output_IR         = ir_q;
  assign output_opcode     = ir_q[DATA_W-1 -: 4];
  assign output_fault_code = code_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the driver pushes the outcome
// each fetch must produce, the monitor pops and compares on done/fault events.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        input_reset;
  logic [15:0] input_PC;
  logic        input_fetch_start;
  logic        input_fault_clear;
  logic        input_mem_ready;
  logic [15:0] input_mem_rdata;
  logic        output_mem_req;
  logic [15:0] output_mem_addr;
  logic [15:0] output_IR;
  logic [3:0]  output_opcode;
  logic        output_fetch_done;
  logic        output_busy;
  logic        output_fault;
  logic [1:0]  output_fault_code;

  instruction_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(15)) dut (
    .CLK               (CLK),
    .input_reset       (input_reset),
    .input_PC          (input_PC),
    .input_fetch_start (input_fetch_start),
    .input_fault_clear (input_fault_clear),
    .input_mem_ready   (input_mem_ready),
    .input_mem_rdata   (input_mem_rdata),
    .output_mem_req    (output_mem_req),
    .output_mem_addr   (output_mem_addr),
    .output_IR         (output_IR),
    .output_opcode     (output_opcode),
    .output_fetch_done (output_fetch_done),
    .output_busy       (output_busy),
    .output_fault      (output_fault),
    .output_fault_code (output_fault_code)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_fault;
    logic [1:0]  code;
    logic [15:0] ir;
    logic [15:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_ir = 16'h0000;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  bit          prev_done = 1'b0;
  bit          prev_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the scoreboard away from the rising edge.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (output_mem_req) begin
        if (exp_q.size() == 0) check("req_unexpected", 1, 0);
        else                   check("mem_addr", output_mem_addr, exp_q[0].addr);
        check("req_not_fault", output_fault, 0);
      end
      if (output_fetch_done) begin
        check("done_one_cycle", prev_done, 0);
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("done_kind", e.is_fault, 0);
          check("IR", output_IR, e.ir);
          check("opcode", output_opcode, e.ir >> 12);
          check("busy_in_done", output_busy, 1);
          exp_ir = e.ir;
        end
      end else begin
        check("IR_hold", output_IR, exp_ir);
      end
      if (output_fault && !prev_fault) begin
        if (exp_q.size() == 0) check("fault_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("fault_kind", e.is_fault, 1);
          check("fault_code", output_fault_code, e.code);
          check("fault_busy", output_busy, 1);
        end
      end
      prev_done  = output_fetch_done;
      prev_fault = output_fault;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fetch: reference outcome is the memory word for an even PC, a
  // misaligned fault with IR untouched for an odd PC.
  task automatic fetch(input logic [15:0] pc, input logic [15:0] rd,
                       input int nwait, input bit poke);
    exp_t e;
    e.is_fault = pc[0];
    e.code     = pc[0] ? 2'b01 : 2'b00;
    e.ir       = rd;
    e.addr     = pc;
    exp_q.push_back(e);
    input_PC          = pc;
    input_fetch_start = 1'b1;
    input_mem_ready   = 1'b0;
    tick();
    input_fetch_start = 1'b0;
    if (pc[0]) begin
      repeat ($urandom_range(1, 3)) begin
        if (poke) begin
          input_fetch_start = 1'b1;
          input_PC          = 16'h0040;
        end
        tick();
      end
      input_fetch_start = 1'b0;
      check("misalign_fault", output_fault, 1);
      check("misalign_code", output_fault_code, 2'b01);
      check("misalign_no_req", output_mem_req, 0);
      input_fault_clear = 1'b1;
      tick();
      input_fault_clear = 1'b0;
      check("clear_fault", output_fault, 0);
      check("clear_code", output_fault_code, 2'b00);
      check("clear_busy", output_busy, 0);
    end else begin
      for (int i = 0; i < nwait; i++) begin
        input_mem_ready   = 1'b0;
        input_mem_rdata   = 16'($urandom);
        input_fetch_start = poke && (i == 0);
        if (poke) input_PC = 16'h0020;
        tick();
      end
      input_fetch_start = poke;
      input_mem_ready   = 1'b1;
      input_mem_rdata   = rd;
      tick();
      input_mem_ready   = 1'($urandom);
      input_mem_rdata   = 16'($urandom);
      input_fetch_start = poke;
      tick();
      input_fetch_start = 1'b0;
      input_mem_ready   = 1'($urandom);
      input_mem_rdata   = 16'($urandom);
      check("idle_after_done", output_busy, 0);
      input_mem_ready   = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    input_reset       = 1'b1;
    input_PC          = 16'h0002;
    input_fetch_start = 1'b1;
    input_fault_clear = 1'b0;
    input_mem_ready   = 1'b1;
    input_mem_rdata   = 16'hFFFF;
    repeat (3) tick();
    check("rst_req", output_mem_req, 0);
    check("rst_busy", output_busy, 0);
    check("rst_IR", output_IR, 16'h0000);
    check("rst_addr", output_mem_addr, 16'h0000);
    check("rst_code", output_fault_code, 2'b00);
    check("rst_fault", output_fault, 0);
    check("rst_done", output_fetch_done, 0);
    input_reset       = 1'b0;
    input_fetch_start = 1'b0;
    input_mem_ready   = 1'b0;
    tick();
    mon_en = 1'b1;

    // Directed scenarios
    fetch(16'h0002, 16'h1234, 0, 1'b0);
    fetch(16'h0010, 16'hA5C3, 3, 1'b0);
    fetch(16'h0003, 16'h0000, 0, 1'b0);
    fetch(16'h0004, 16'h7E01, 1, 1'b0);
    fetch(16'h0008, 16'h3C3C, 2, 1'b1);
    fetch(16'hFFFE, 16'hBEEF, 0, 1'b0);
    fetch(16'hFFFF, 16'h0000, 0, 1'b1);
    fetch(16'h0100, 16'h5A5A, 14, 1'b0);

    // Reset in the middle of a request
    e.is_fault = 1'b0; e.code = 2'b00; e.ir = 16'h0000; e.addr = 16'h0030;
    exp_q.push_back(e);
    input_PC = 16'h0030; input_fetch_start = 1'b1;
    tick();
    input_fetch_start = 1'b0;
    repeat (2) tick();
    check("midreq_req", output_mem_req, 1);
    input_reset = 1'b1;
    tick();
    input_reset = 1'b0;
    void'(exp_q.pop_front());
    exp_ir = 16'h0000;
    check("midrst_req", output_mem_req, 0);
    check("midrst_IR", output_IR, 16'h0000);
    check("midrst_busy", output_busy, 0);
    input_mem_ready = 1'b1; input_mem_rdata = 16'hDEAD;
    repeat (3) begin
      tick();
      check("late_ready_done", output_fetch_done, 0);
      check("late_ready_IR", output_IR, 16'h0000);
    end
    input_mem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    e.is_fault = 1'b1; e.code = 2'b10; e.ir = 16'h0000; e.addr = 16'h0040;
    exp_q.push_back(e);
    input_PC = 16'h0040; input_fetch_start = 1'b1;
    tick();
    input_fetch_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (output_fault) break;
      if (output_mem_req) n++;
      tick();
    end
    check("timeout_req_cycles", n, 15);
    check("timeout_fault", output_fault, 1);
    check("timeout_code", output_fault_code, 2'b10);
    check("timeout_no_req", output_mem_req, 0);
    input_fault_clear = 1'b1;
    tick();
    input_fault_clear = 1'b0;
    check("timeout_clear_code", output_fault_code, 2'b00);
`else
    e.is_fault = 1'b0; e.code = 2'b00; e.ir = 16'h4321; e.addr = 16'h0040;
    exp_q.push_back(e);
    input_PC = 16'h0040; input_fetch_start = 1'b1;
    tick();
    input_fetch_start = 1'b0;
    repeat (100) tick();
    check("no_timeout_req", output_mem_req, 1);
    check("no_timeout_fault", output_fault, 0);
    input_mem_ready = 1'b1; input_mem_rdata = 16'h4321;
    tick();
    input_mem_ready = 1'b0;
    tick();
`endif

    // Randomized fetches
    for (int t = 0; t < 40; t++) begin
      logic [15:0] pc;
      pc = 16'($urandom);
      if ($urandom_range(0, 4) != 0) pc[0] = 1'b0;
      fetch(pc, 16'($urandom), int'($urandom_range(0, 14)), 1'($urandom));
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
